// File: rtl/axi_pkg.sv
// Minimal AXI type definitions shared by the HyperBus front end.
package axi_pkg;

  typedef logic [7:0] len_t;
  typedef logic [1:0] burst_t;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;

endpackage

// File: rtl/hyperbus_pkg.sv
// HyperBus types: PHY transfer descriptor, scheduler state/direction enums and
// the default AXI request struct seen by the transaction scheduler.
package hyperbus_pkg;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefIdWidth   = 4;
  localparam int unsigned DefNumChips  = 2;

  typedef struct packed {
    logic [31:0] address;
    logic [15:0] burst;
    logic        burst_type;
    logic        address_space;
  } hyper_tf_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } hyper_sched_state_e;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } hyper_dir_e;

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [DefIdWidth-1:0]   id;
    axi_pkg::len_t           len;
    axi_pkg::burst_t         burst;
    logic [DefNumChips-1:0]  cs;
  } hyper_ax_req_t;

endpackage

// File: rtl/hyperbus_trans_sched_if.sv
// AW/AR request channels between the AXI front end (master) and the
// transaction scheduler (slave).
interface hyperbus_trans_sched_if #(
  parameter type ax_req_t = hyperbus_pkg::hyper_ax_req_t
);

  ax_req_t aw;
  logic    aw_valid;
  logic    aw_ready;
  ax_req_t ar;
  logic    ar_valid;
  logic    ar_ready;

  modport master (
    output aw, aw_valid, ar, ar_valid,
    input  aw_ready, ar_ready
  );

  modport slave (
    input  aw, aw_valid, ar, ar_valid,
    output aw_ready, ar_ready
  );

endinterface

// File: rtl/hyperbus_sched_arb.sv
// Direction arbiter for the transaction scheduler. Round-robin by default;
// with HYPERBUS_SCHED_READ_PRIO_EN reads win unless writes have starved.
module hyperbus_sched_arb
  import hyperbus_pkg::*;
#(
  parameter int unsigned StarveLimit = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       aw_valid_i,
  input  logic       ar_valid_i,
  output hyper_dir_e grant_dir_o,
  output logic       grant_valid_o
);

  hyper_dir_e last_dir_q, last_dir_d;

`ifdef HYPERBUS_SCHED_READ_PRIO_EN
  localparam int unsigned CntWidth = $clog2(StarveLimit + 1);
  logic [CntWidth-1:0] starve_cnt_q, starve_cnt_d;
  logic                starved;

  assign starved = (starve_cnt_q == CntWidth'(StarveLimit));
`endif

  always_comb begin
    grant_valid_o = en_i && (aw_valid_i || ar_valid_i);
    grant_dir_o   = DIR_READ;
    if (aw_valid_i && ar_valid_i) begin
`ifdef HYPERBUS_SCHED_READ_PRIO_EN
      grant_dir_o = starved ? DIR_WRITE : DIR_READ;
`else
      grant_dir_o = (last_dir_q == DIR_WRITE) ? DIR_READ : DIR_WRITE;
`endif
    end else if (aw_valid_i) begin
      grant_dir_o = DIR_WRITE;
    end else begin
      grant_dir_o = DIR_READ;
    end

    last_dir_d = last_dir_q;
    if (grant_valid_o) begin
      last_dir_d = grant_dir_o;
    end else begin
      last_dir_d = last_dir_q;
    end

`ifdef HYPERBUS_SCHED_READ_PRIO_EN
    // A write waiting behind a read grant ages; any write grant forgives it.
    starve_cnt_d = starve_cnt_q;
    if (grant_valid_o && (grant_dir_o == DIR_WRITE)) begin
      starve_cnt_d = '0;
    end else if (grant_valid_o && aw_valid_i && !starved) begin
      starve_cnt_d = starve_cnt_q + CntWidth'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_dir_q <= DIR_WRITE;
`ifdef HYPERBUS_SCHED_READ_PRIO_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      last_dir_q <= last_dir_d;
`ifdef HYPERBUS_SCHED_READ_PRIO_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

endmodule

// File: rtl/hyperbus_trans_sched.sv
// HyperBus transaction scheduler: one PHY transfer at a time, ID/direction held
// until its response completes. Optional macro: HYPERBUS_SCHED_READ_PRIO_EN.
module hyperbus_trans_sched
  import hyperbus_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned NumChips    = 2,
  parameter int unsigned StarveLimit = 4,
  parameter type         ax_req_t    = hyper_ax_req_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  hyperbus_trans_sched_if.slave req_if,
  output hyper_tf_t            trans_o,
  output logic [NumChips-1:0]  trans_cs_o,
  output logic                 trans_write_o,
  output logic                 trans_valid_o,
  input  logic                 trans_ready_i,
  input  logic                 r_done_i,
  input  logic                 b_done_i,
  output logic [IdWidth-1:0]   rsp_id_o,
  output logic                 rsp_write_o,
  output logic                 rsp_valid_o,
  output logic                 busy_o,
  output logic                 proto_err_o
);

  hyper_sched_state_e   state_q, state_d;
  hyper_dir_e           dir_q, dir_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [IdWidth-1:0]   id_q, id_d;
  axi_pkg::len_t        len_q, len_d;
  logic                 btype_q, btype_d;
  logic [NumChips-1:0]  cs_q, cs_d;
  logic                 err_q, err_d;

  logic       arb_en;
  logic       grant_valid;
  hyper_dir_e grant_dir;
  logic       done_ok;
  logic       done_bad;

  assign arb_en = (state_q == IDLE) && !rst_i;

  hyperbus_sched_arb #(
    .StarveLimit (StarveLimit)
  ) i_arb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (arb_en),
    .aw_valid_i    (req_if.aw_valid),
    .ar_valid_i    (req_if.ar_valid),
    .grant_dir_o   (grant_dir),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    btype_d = btype_q;
    cs_d    = cs_q;
    err_d   = err_q;
    req_if.aw_ready = 1'b0;
    req_if.ar_ready = 1'b0;

    done_ok  = (dir_q == DIR_WRITE) ? b_done_i : r_done_i;
    done_bad = (dir_q == DIR_WRITE) ? r_done_i : b_done_i;

    case (state_q)
      IDLE: begin
        if (r_done_i || b_done_i) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (arb_en && grant_valid) begin
          req_if.aw_ready = (grant_dir == DIR_WRITE);
          req_if.ar_ready = (grant_dir == DIR_READ);
          dir_d   = grant_dir;
          state_d = ISSUE;
          if (grant_dir == DIR_WRITE) begin
            addr_d  = req_if.aw.addr;
            id_d    = req_if.aw.id;
            len_d   = req_if.aw.len;
            btype_d = req_if.aw.burst[0];
            cs_d    = req_if.aw.cs;
          end else begin
            addr_d  = req_if.ar.addr;
            id_d    = req_if.ar.id;
            len_d   = req_if.ar.len;
            btype_d = req_if.ar.burst[0];
            cs_d    = req_if.ar.cs;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // The response cannot precede the transfer, even in the handshake cycle.
        if (r_done_i || b_done_i) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (trans_ready_i) begin
          state_d = WAIT_RSP;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT_RSP: begin
        if (done_bad) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (done_ok) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_RSP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      dir_q   <= DIR_READ;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      btype_q <= 1'b0;
      cs_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      btype_q <= btype_d;
      cs_q    <= cs_d;
      err_q   <= err_d;
    end
  end

  assign trans_o.address       = 32'(addr_q);
  assign trans_o.burst         = 16'(len_q);
  assign trans_o.burst_type    = btype_q;
  assign trans_o.address_space = addr_q[AddrWidth-1];
  assign trans_cs_o    = cs_q;
  assign trans_write_o = (dir_q == DIR_WRITE);
  assign trans_valid_o = (state_q == ISSUE);
  assign rsp_id_o      = id_q;
  assign rsp_write_o   = (dir_q == DIR_WRITE);
  assign rsp_valid_o   = (state_q == ISSUE) || (state_q == WAIT_RSP);
  assign busy_o        = (state_q != IDLE);
  assign proto_err_o   = err_q;

endmodule

// File: tb/tb_hyperbus_trans_sched.sv
// Randomized bench for hyperbus_trans_sched against a transaction-level model,
// plus directed scenarios (single read, contention order, backpressure, errors).
module tb_hyperbus_trans_sched;
  import hyperbus_pkg::*;

  localparam int StarveLimit = 4;

  logic            clk = 1'b0;
  logic            rst_i;
  hyper_tf_t       trans_o;
  logic [1:0]      trans_cs_o;
  logic            trans_write_o, trans_valid_o, trans_ready_i;
  logic            r_done_i, b_done_i;
  logic [3:0]      rsp_id_o;
  logic            rsp_write_o, rsp_valid_o, busy_o, proto_err_o;

  hyperbus_trans_sched_if bus ();

  hyperbus_trans_sched #(.StarveLimit(StarveLimit)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_if        (bus.slave),
    .trans_o       (trans_o),
    .trans_cs_o    (trans_cs_o),
    .trans_write_o (trans_write_o),
    .trans_valid_o (trans_valid_o),
    .trans_ready_i (trans_ready_i),
    .r_done_i      (r_done_i),
    .b_done_i      (b_done_i),
    .rsp_id_o      (rsp_id_o),
    .rsp_write_o   (rsp_write_o),
    .rsp_valid_o   (rsp_valid_o),
    .busy_o        (busy_o),
    .proto_err_o   (proto_err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: one outstanding transfer, issued flag, sticky error.
  bit            m_busy, m_issued, m_dir_write, m_last_write, m_err;
  int            m_starve;
  hyper_ax_req_t m_req;
  bit            dut_order[$];

  task automatic model_reset();
    m_busy = 0; m_issued = 0; m_dir_write = 0; m_last_write = 1; m_err = 0;
    m_starve = 0; m_req = '0;
  endtask

  function automatic int model_grant(input bit awv, input bit arv);
    if (!awv && !arv) return -1;
    if (awv && !arv)  return 1;
    if (arv && !awv)  return 0;
`ifdef HYPERBUS_SCHED_READ_PRIO_EN
    return (m_starve == StarveLimit) ? 1 : 0;
`else
    return m_last_write ? 0 : 1;
`endif
  endfunction

  function automatic hyper_ax_req_t rand_req();
    hyper_ax_req_t r;
    r.addr  = $urandom;
    r.id    = 4'($urandom);
    r.len   = 8'($urandom);
    r.burst = 2'($urandom_range(0, 2));
    r.cs    = 2'b01 << $urandom_range(0, 1);
    return r;
  endfunction

  task automatic step(input bit awv, input hyper_ax_req_t awr, input bit arv,
                      input hyper_ax_req_t arr, input bit trdy, input bit rd,
                      input bit bd, input bit rst, output int g);
    bit ok;
    bus.aw = awr; bus.aw_valid = awv; bus.ar = arr; bus.ar_valid = arv;
    trans_ready_i = trdy; r_done_i = rd; b_done_i = bd; rst_i = rst;
    #2;
    g = (rst || m_busy) ? -1 : model_grant(awv, arv);
    check_val("aw_ready", bus.aw_ready, (g == 1));
    check_val("ar_ready", bus.ar_ready, (g == 0));
    check_val("trans_valid", trans_valid_o, (m_busy && !m_issued));
    check_val("trans_addr", trans_o.address, m_req.addr);
    check_val("trans_burst", trans_o.burst, m_req.len);
    check_val("trans_btype", trans_o.burst_type, m_req.burst[0]);
    check_val("trans_aspace", trans_o.address_space, m_req.addr[31]);
    check_val("trans_cs", trans_cs_o, m_req.cs);
    check_val("trans_write", trans_write_o, m_dir_write);
    check_val("rsp_id", rsp_id_o, m_req.id);
    check_val("rsp_write", rsp_write_o, m_dir_write);
    check_val("rsp_valid", rsp_valid_o, m_busy);
    check_val("busy", busy_o, m_busy);
    check_val("proto_err", proto_err_o, m_err);
    if (trans_valid_o && trdy && !rst) dut_order.push_back(trans_write_o);

    if (rst) begin
      model_reset();
    end else begin
      ok = m_busy && m_issued && (m_dir_write ? bd : rd);
      if ((rd || bd) && !(m_busy && m_issued)) m_err = 1;
      if (m_busy && m_issued && (m_dir_write ? rd : bd)) m_err = 1;
      if (g >= 0) begin
        m_busy = 1; m_issued = 0; m_dir_write = (g == 1);
        m_req = (g == 1) ? awr : arr;
`ifdef HYPERBUS_SCHED_READ_PRIO_EN
        if (g == 0 && awv) m_starve++;
        if (g == 1) m_starve = 0;
`endif
        m_last_write = (g == 1);
      end else if (m_busy && !m_issued && trdy) begin
        m_issued = 1;
      end else if (ok) begin
        m_busy = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int g;
    step(0, '0, 0, '0, 0, 0, 0, 1, g);
    dut_order.delete();
  endtask

  task automatic run_random(input int n, input bit err_inj);
    bit pa = 0, pr = 0, trdy, rd, bd;
    hyper_ax_req_t qa = '0, qr = '0;
    int g;
    for (int i = 0; i < n; i++) begin
      if (!pa && $urandom_range(0, 2) == 0) begin pa = 1; qa = rand_req(); end
      if (!pr && $urandom_range(0, 2) == 0) begin pr = 1; qr = rand_req(); end
      trdy = ($urandom_range(0, 3) != 0);
      rd = m_busy && m_issued && !m_dir_write && ($urandom_range(0, 2) == 0);
      bd = m_busy && m_issued && m_dir_write && ($urandom_range(0, 2) == 0);
      if (err_inj && $urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 0) rd = 1; else bd = 1;
      end
      step(pa, qa, pr, qr, trdy, rd, bd, 0, g);
      if (g == 1) pa = 0;
      if (g == 0) pr = 0;
    end
  endtask

  hyper_ax_req_t ra, rr;
  hyper_tf_t     saved;
  bit            exp_ord[6];
  int            g;

  initial begin
    rst_i = 1; trans_ready_i = 0; r_done_i = 0; b_done_i = 0;
    bus.aw = '0; bus.aw_valid = 0; bus.ar = '0; bus.ar_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    check_val("rst_busy", busy_o, 0);
    check_val("rst_trans_valid", trans_valid_o, 0);
    check_val("rst_cs", trans_cs_o, 0);

    // Single read.
    rr = '{addr: 32'h0000_1000, id: 4'd3, len: 8'd7, burst: axi_pkg::BURST_INCR, cs: 2'b01};
    step(0, '0, 1, rr, 1, 0, 0, 0, g);
    check_val("sr_valid", trans_valid_o, 1);
    check_val("sr_addr", trans_o.address, 32'h1000);
    check_val("sr_burst", trans_o.burst, 16'd7);
    check_val("sr_btype", trans_o.burst_type, 1);
    check_val("sr_write", trans_write_o, 0);
    step(0, '0, 0, '0, 1, 0, 0, 0, g);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 0, '0, 0, 0, 0, 0, g);
      check_val("sr_id", rsp_id_o, 4'd3);
    end
    check_val("sr_busy_hold", busy_o, 1);
    step(0, '0, 0, '0, 0, 1, 0, 0, g);
    check_val("sr_busy_fall", busy_o, 0);

    // Contention order from a fresh reset.
    do_reset();
    ra = rand_req(); rr = rand_req();
    for (int i = 0; i < 200 && dut_order.size() < 6; i++)
      step(1, ra, 1, rr, 1, m_busy && m_issued && !m_dir_write,
           m_busy && m_issued && m_dir_write, 0, g);
`ifdef HYPERBUS_SCHED_READ_PRIO_EN
    exp_ord = '{0, 0, 0, 0, 1, 0};
`else
    exp_ord = '{0, 1, 0, 1, 0, 1};
`endif
    check_val("ord_cnt", dut_order.size(), 6);
    for (int i = 0; i < 6 && i < dut_order.size(); i++)
      check_val($sformatf("ord%0d", i), dut_order[i], exp_ord[i]);

    // PHY backpressure.
    do_reset();
    ra = rand_req();
    step(1, ra, 0, '0, 0, 0, 0, 0, g);
    saved = trans_o;
    ra = rand_req(); rr = rand_req();
    for (int i = 0; i < 5; i++) begin
      step(1, ra, 1, rr, 0, 0, 0, 0, g);
      check_val("bp_stable", trans_o, saved);
      check_val("bp_valid", trans_valid_o, 1);
    end
    step(0, '0, 0, '0, 1, 0, 0, 0, g);
    step(0, '0, 0, '0, 0, 0, 1, 0, g);

    // Wrong-kind done during a read, then reset in WAIT_RSP.
    do_reset();
    rr = rand_req();
    step(0, '0, 1, rr, 1, 0, 0, 0, g);
    step(0, '0, 0, '0, 1, 0, 0, 0, g);
    step(0, '0, 0, '0, 0, 0, 1, 0, g);
    check_val("err_b_in_read", proto_err_o, 1);
    check_val("err_busy_kept", busy_o, 1);
    step(0, '0, 0, '0, 0, 0, 0, 1, g);
    check_val("rst_mid_busy", busy_o, 0);
    check_val("rst_mid_rsp_valid", rsp_valid_o, 0);
    check_val("rst_mid_err", proto_err_o, 0);
    step(0, '0, 0, '0, 0, 1, 0, 0, g);
    check_val("err_r_idle", proto_err_o, 1);

    // Randomized traffic, clean then with stray done pulses.
    do_reset();
    run_random(600, 0);
    do_reset();
    run_random(400, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hyperbus_trans_sched.md
# hyperbus_trans_sched

Transaction scheduler between the narrow (16-bit) AXI side of the HyperBus front end and the PHY transaction port. It arbitrates AW and AR requests, issues exactly one PHY transfer at a time, and holds that transfer's ID and direction until its response completes (last R beat or B). Downstream R/B channels therefore get a stable ID instead of one taken from the live arbiter output.

## Interface
Parameters:
- `AddrWidth`, 32: AXI address width; MSB selects `address_space`.
- `IdWidth`, 4: AXI ID width.
- `NumChips`, 2: number of chip selects.
- `StarveLimit`, 4: consecutive read grants allowed while a write waits (used only with the macro).
- `ax_req_t`, logic: packed struct with fields `addr [AddrWidth]`, `id [IdWidth]`, `len` (axi_pkg::len_t), `burst` (axi_pkg::burst_t), `cs [NumChips]` (one-hot, decoded upstream).

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous active-high reset.
- `aw_i` in ax_req_t: write request.
- `aw_valid_i` in 1, `aw_ready_o` out 1: write request handshake.
- `ar_i` in ax_req_t: read request.
- `ar_valid_i` in 1, `ar_ready_o` out 1: read request handshake.
- `trans_o` out hyperbus_pkg::hyper_tf_t: PHY transfer descriptor.
- `trans_cs_o` out NumChips: one-hot chip select.
- `trans_write_o` out 1: 1 = write transfer.
- `trans_valid_o` out 1, `trans_ready_i` in 1: PHY transfer handshake.
- `r_done_i` in 1: pulse on the last R beat handshake.
- `b_done_i` in 1: pulse on the B handshake.
- `rsp_id_o` out IdWidth: ID of the in-flight transfer.
- `rsp_write_o` out 1: direction of the in-flight transfer.
- `rsp_valid_o` out 1: `rsp_id_o` and `rsp_write_o` are meaningful.
- `busy_o` out 1: state != IDLE.
- `proto_err_o` out 1: sticky protocol error flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP.
- IDLE:
  - Select a direction (see arbitration). Assert the matching ready combinationally; the other ready stays 0.
  - On the handshake, latch the request and its direction, then go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE:
  - `trans_valid_o`=1, driven from registers only.
  - On `trans_ready_i`, go to WAIT_RSP.
- WAIT_RSP:
  - A read transfer leaves on `r_done_i`; a write transfer leaves on `b_done_i`. Both go to IDLE.
  - A done pulse of the wrong kind is ignored and sets `proto_err_o`.
- Any done pulse in IDLE or ISSUE is ignored and sets `proto_err_o`.
- `trans_o` fields:
  - `address` = addr
  - `burst` = len
  - `burst_type` = burst[0]
  - `address_space` = addr[AddrWidth-1]
- `trans_cs_o` = latched cs. The latched value is passed through unchanged; it is not checked for one-hot.
- `rsp_valid_o`=1 in ISSUE and WAIT_RSP. Outside those states `rsp_id_o` holds its last value.
- Default arbitration: round-robin on direction. With both valid, grant the direction opposite to the last grant. `last_dir` resets to write, so the first contention goes to read.

## Timing
- Reset values:
  - state IDLE, all registers 0
  - `trans_valid_o`=0, `trans_cs_o`=0, `trans_write_o`=0
  - `rsp_valid_o`=0, `busy_o`=0, `proto_err_o`=0
- Readies are 0 in reset and whenever the FSM is not in IDLE.
- Request handshake in cycle N → `trans_valid_o`=1 from N+1.
- `trans_valid_o` is held with stable `trans_o` until `trans_ready_i`. If `trans_ready_i` is high at N+1, the handshake completes at N+1.
- Done pulse in cycle M → IDLE at M+1 → next request can be accepted at M+1. Minimum turnaround: 3 cycles for back-to-back transfers.
- Done in the same cycle as the PHY handshake in ISSUE: counts as an error and is ignored, because the response cannot precede the issued transfer.
- Reset asserted mid-transfer: at the next edge all outputs return to reset values and the in-flight context is dropped. The PHY must be reset together with this block.
- `proto_err_o` is cleared only by `rst_i`.

## Configuration
- Macro `HYPERBUS_SCHED_READ_PRIO_EN`.
- Defined: reads win contention. A counter `starve_cnt` (width clog2(StarveLimit+1), resets to 0):
  - increments on each read grant while `aw_valid_i`=1
  - clears on any write grant
  - when `starve_cnt`==StarveLimit and both requests are valid, the write is granted
- Undefined: round-robin as described in Operation. The counter is not instantiated.

## Structure
- In hyperbus_pkg: enum `hyper_sched_state_e` (IDLE, ISSUE, WAIT_RSP) and enum `hyper_dir_e` (DIR_READ=0, DIR_WRITE=1). `hyper_tf_t` is already there.
- Sub-module `hyperbus_sched_arb` holds the direction selection, `last_dir` and the macro-gated starvation counter. Its inputs are both valids plus an `en` (IDLE); its outputs are `grant_dir` and `grant_valid`.

## Test plan
- Single read: ar {addr=0x0000_1000, id=3, len=7, burst=INCR}, `trans_ready_i`=1.
  - → `trans_o.address`=0x1000, `burst`=7, `burst_type`=1, `trans_write_o`=0 at N+1.
  - → `rsp_id_o`=3 until `r_done_i`; `busy_o` falls the cycle after.
- Contention, macro undefined: aw and ar valid continuously for 4 transfers → grant order R,W,R,W.
- Contention, macro defined, StarveLimit=4: aw and ar valid continuously → grants R,R,R,R,W,R,...
- PHY backpressure: `trans_ready_i` held 0 for 5 cycles → `trans_valid_o` and `trans_o` stable, both readies 0, new aw not accepted.
- Errors:
  - `b_done_i` during an in-flight read → `proto_err_o`=1, state unchanged.
  - `r_done_i` in IDLE → `proto_err_o`=1.
- Reset in WAIT_RSP → next cycle state IDLE, `rsp_valid_o`=0, `proto_err_o`=0.
